// File: rtl/sd_dat_pkg.sv
// sd_dat_pkg: shared definitions for the SD DAT0 serial engine.
//   tx_state_t / rx_state_t : state encodings of the TX and RX FSMs
//   START_BIT, END_BIT      : DAT0 line framing levels
//   CRC16_POLY              : CRC-16-CCITT polynomial x^16+x^12+x^5+1
//   CRC_OK_TOKEN            : CRC-status token meaning "data accepted"
package sd_dat_pkg;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_CRC,
        TX_END,
        TX_DONE,
        TX_HOLD
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_DATA,
        RX_TOKEN,
        RX_CRC,
        RX_END,
        RX_DONE,
        RX_HOLD
    } rx_state_t;

    localparam logic        START_BIT    = 1'b0;
    localparam logic        END_BIT      = 1'b1;
    localparam logic [15:0] CRC16_POLY   = 16'h1021;
    localparam logic [2:0]  CRC_OK_TOKEN = 3'b010;

endpackage

// File: rtl/sd_crc16.sv
// sd_crc16: bit-serial CRC-16 (x^16+x^12+x^5+1), initial value 0.
//   clk    : clock, rising edge
//   reset  : synchronous active-low reset
//   clear  : synchronous clear to 0 (priority over enable)
//   enable : consume bit_in this cycle
//   bit_in : serial data bit, MSB of the message first
//   crc    : current CRC register
module sd_crc16
    import sd_dat_pkg::*;
#(
    parameter int CRC_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic             bit_in,
    output logic [CRC_W-1:0] crc
);

    logic feedback;

    assign feedback = crc[CRC_W-1] ^ bit_in;

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            crc <= '0;
        end else if (enable) begin
            crc <= {crc[CRC_W-2:0], 1'b0} ^ (feedback ? CRC_W'(CRC16_POLY) : '0);
        end
    end

endmodule

// File: rtl/sd_dat_serdes.sv
// sd_dat_serdes: serial engine for the SD DAT0 line.
//   sd_clock, reset (sync, active-low), reset_wrapper (sync soft clear)
//   enable_pts_wrapper, load_send, data_in      : TX control and payload
//   dat_out, transmission_complete              : TX line and done pulse
//   enable_stp_wrapper, waiting_response, dat_in: RX control and line
//   reception_complete, dataRead, crc_status,
//   crc_status_ok, crc_error                    : RX done pulse and held results
// The internal tx_state / rx_state registers carry the FSM state for debug.
// Line handshake: every DAT0 bit lasts exactly one sd_clock cycle; the
// controller starts a TX block with a load_send level that must drop before
// the next block, and RX results are valid when reception_complete pulses
// and stay held until the next frame ends or a clear.
module sd_dat_serdes
    import sd_dat_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int CRC_W   = 16,
    parameter int TOKEN_W = 3
) (
    input  logic               sd_clock,
    input  logic               reset,
    input  logic               reset_wrapper,
    input  logic               enable_pts_wrapper,
    input  logic               load_send,
    input  logic               enable_stp_wrapper,
    input  logic               waiting_response,
    input  logic [DATA_W-1:0]  data_in,
    input  logic               dat_in,
    output logic               dat_out,
    output logic               transmission_complete,
    output logic               reception_complete,
    output logic [DATA_W-1:0]  dataRead,
    output logic [TOKEN_W-1:0] crc_status,
    output logic               crc_status_ok,
    output logic               crc_error
);

    localparam int CNT_W  = 6;
    localparam int CRC_IW = $clog2(CRC_W);
    localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(DATA_W + CRC_W - 1);
    localparam logic [CNT_W-1:0] TOKEN_LAST = CNT_W'(TOKEN_W - 1);

    tx_state_t          tx_state;
    rx_state_t          rx_state;
    logic [CNT_W-1:0]   tx_cnt;
    logic [CNT_W-1:0]   rx_cnt;
    logic [DATA_W-1:0]  tx_shift;
    logic [DATA_W-1:0]  rx_shift;
    logic [CRC_W-1:0]   rx_crc_bits;
    logic [TOKEN_W-1:0] rx_tok;
    logic               rx_mode;
    logic [CRC_W-1:0]   tx_crc;
    logic [CRC_W-1:0]   rx_crc;
    logic [CRC_IW-1:0]  tx_crc_idx;
    logic               soft_clear;
    logic               tx_load;
    logic               rx_start;

    assign soft_clear = reset_wrapper;
    assign tx_load    = (tx_state == TX_IDLE) && enable_pts_wrapper && load_send;
    assign rx_start   = (rx_state == RX_IDLE) && enable_stp_wrapper && (dat_in == START_BIT);

    // The TX CRC register is frozen once TX_DATA ends, so it is read out by
    // index (count 32..47 maps to bit 15..0) instead of being shifted.
    assign tx_crc_idx = CRC_IW'(FRAME_LAST - tx_cnt);

    sd_crc16 #(.CRC_W(CRC_W)) u_tx_crc (
        .clk    (sd_clock),
        .reset  (reset),
        .clear  (soft_clear || tx_load),
        .enable (tx_state == TX_DATA),
        .bit_in (tx_shift[DATA_W-1]),
        .crc    (tx_crc)
    );

    sd_crc16 #(.CRC_W(CRC_W)) u_rx_crc (
        .clk    (sd_clock),
        .reset  (reset),
        .clear  (soft_clear || rx_start),
        .enable (rx_state == RX_DATA),
        .bit_in (dat_in),
        .crc    (rx_crc)
    );

    // TX FSM
    always_ff @(posedge sd_clock) begin
        if (!reset || soft_clear || !enable_pts_wrapper) begin
            tx_state              <= TX_IDLE;
            tx_cnt                <= '0;
            dat_out               <= 1'b1;
            transmission_complete <= 1'b0;
            if (!reset || soft_clear) begin
                tx_shift <= '0;
            end
        end else begin
            transmission_complete <= 1'b0;
            case (tx_state)
                TX_IDLE: begin
                    dat_out <= 1'b1;
                    if (load_send) begin
                        tx_shift <= data_in;
                        tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    dat_out  <= START_BIT;
                    tx_cnt   <= '0;
                    tx_state <= TX_DATA;
                end
                TX_DATA: begin
                    dat_out  <= tx_shift[DATA_W-1];
                    tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
                    tx_cnt   <= tx_cnt + 1'b1;
                    if (tx_cnt == DATA_LAST) tx_state <= TX_CRC;
                end
                TX_CRC: begin
                    dat_out <= tx_crc[tx_crc_idx];
                    tx_cnt  <= tx_cnt + 1'b1;
                    if (tx_cnt == FRAME_LAST) tx_state <= TX_END;
                end
                TX_END: begin
                    dat_out  <= END_BIT;
                    tx_state <= TX_DONE;
                end
                TX_DONE: begin
                    transmission_complete <= 1'b1;
                    tx_state              <= TX_HOLD;
                end
                TX_HOLD: begin
                    // Block retrigger while the controller still holds load_send.
                    if (!load_send) tx_state <= TX_IDLE;
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    // RX FSM
    always_ff @(posedge sd_clock) begin
        if (!reset || soft_clear) begin
            rx_state           <= RX_IDLE;
            rx_cnt             <= '0;
            rx_mode            <= 1'b0;
            rx_shift           <= '0;
            rx_crc_bits        <= '0;
            rx_tok             <= '0;
            reception_complete <= 1'b0;
            dataRead           <= '0;
            crc_status         <= '0;
            crc_status_ok      <= 1'b0;
            crc_error          <= 1'b0;
        end else if (!enable_stp_wrapper && rx_state != RX_IDLE) begin
            // Abort: held results stay untouched.
            rx_state           <= RX_IDLE;
            reception_complete <= 1'b0;
        end else begin
            reception_complete <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_start) begin
                        rx_mode  <= waiting_response;
                        rx_cnt   <= '0;
                        rx_state <= waiting_response ? RX_TOKEN : RX_DATA;
                    end
                end
                RX_DATA: begin
                    rx_shift <= {rx_shift[DATA_W-2:0], dat_in};
                    rx_cnt   <= rx_cnt + 1'b1;
                    if (rx_cnt == DATA_LAST) rx_state <= RX_CRC;
                end
                RX_CRC: begin
                    rx_crc_bits <= {rx_crc_bits[CRC_W-2:0], dat_in};
                    rx_cnt      <= rx_cnt + 1'b1;
                    if (rx_cnt == FRAME_LAST) rx_state <= RX_END;
                end
                RX_TOKEN: begin
                    rx_tok <= {rx_tok[TOKEN_W-2:0], dat_in};
                    rx_cnt <= rx_cnt + 1'b1;
                    if (rx_cnt == TOKEN_LAST) rx_state <= RX_END;
                end
                RX_END: begin
                    if (rx_mode) begin
                        crc_status    <= rx_tok;
                        crc_status_ok <= (rx_tok == TOKEN_W'(CRC_OK_TOKEN)) && (dat_in == END_BIT);
                    end else begin
                        dataRead  <= rx_shift;
                        crc_error <= (rx_crc_bits != rx_crc) || (dat_in != END_BIT);
                    end
                    rx_state <= RX_DONE;
                end
                RX_DONE: begin
                    reception_complete <= 1'b1;
                    rx_state           <= RX_HOLD;
                end
                RX_HOLD: begin
                    rx_state <= RX_HOLD;
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_dat_serdes.sv
// tb_sd_dat_serdes: self-checking bench for sd_dat_serdes.
module tb_sd_dat_serdes;

    localparam int DATA_W  = 32;
    localparam int CRC_W   = 16;
    localparam int TOKEN_W = 3;

    // ---------------- clock / reset ----------------
    logic sd_clock = 1'b0;
    always #5 sd_clock = ~sd_clock;

    logic               reset = 1'b0;
    logic               reset_wrapper = 1'b0;
    logic               enable_pts_wrapper = 1'b0;
    logic               load_send = 1'b0;
    logic               enable_stp_wrapper = 1'b0;
    logic               waiting_response = 1'b0;
    logic [DATA_W-1:0]  data_in = '0;
    logic               dat_in;
    logic               dat_out;
    logic               transmission_complete;
    logic               reception_complete;
    logic [DATA_W-1:0]  dataRead;
    logic [TOKEN_W-1:0] crc_status;
    logic               crc_status_ok;
    logic               crc_error;

    logic loop_en = 1'b0;
    logic dat_drv = 1'b1;
    assign dat_in = loop_en ? dat_out : dat_drv;

    sd_dat_serdes #(.DATA_W(DATA_W), .CRC_W(CRC_W), .TOKEN_W(TOKEN_W)) dut (
        .sd_clock              (sd_clock),
        .reset                 (reset),
        .reset_wrapper         (reset_wrapper),
        .enable_pts_wrapper    (enable_pts_wrapper),
        .load_send             (load_send),
        .enable_stp_wrapper    (enable_stp_wrapper),
        .waiting_response      (waiting_response),
        .data_in               (data_in),
        .dat_in                (dat_in),
        .dat_out               (dat_out),
        .transmission_complete (transmission_complete),
        .reception_complete    (reception_complete),
        .dataRead              (dataRead),
        .crc_status            (crc_status),
        .crc_status_ok         (crc_status_ok),
        .crc_error             (crc_error)
    );

    int cyc = 0;
    always @(posedge sd_clock) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    int n_vec  = 0;
    int n_miss = 0;
    // RX entry: [37]=token mode, [36]=crc_error, [35]=crc_status_ok,
    //           [34:32]=crc_status, [31:0]=dataRead
    logic [37:0] exp_q[$];
    int          exp_cyc_q[$];
    logic [1:0]  tx_q[$];   // {transmission_complete, dat_out} per cycle

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sd_clock);
        #1;
    endtask

    // Reference CRC as the remainder of {word, 16'b0} divided by 0x11021.
    function automatic logic [15:0] crc_model(input logic [31:0] w);
        logic [47:0] r;
        r = {w, 16'h0000};
        for (int i = 47; i >= 16; i--) begin
            if (r[i]) r[i-:17] = r[i-:17] ^ 17'h11021;
        end
        return r[15:0];
    endfunction

    // Compare RX results whenever a completion pulse appears.
    always @(posedge sd_clock) begin
        logic [37:0] e;
        int          c;
        #1;
        if (reception_complete === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("rx_unexpected_pulse", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                c = exp_cyc_q.pop_front();
                check("rx_pulse_cycle", 64'(cyc), 64'(c));
                if (e[37]) begin
                    check("rx_token", {60'd0, crc_status_ok, crc_status}, {60'd0, e[35], e[34:32]});
                end else begin
                    check("rx_data", {31'd0, crc_error, dataRead}, {31'd0, e[36], e[31:0]});
                end
            end
        end
    end

    // ---------------- drivers ----------------
    // Launch one TX block and compare 60 cycles of the line and the pulse.
    // clear_at >= 0 asserts reset_wrapper so that edge clear_at samples it.
    task automatic run_tx(input logic [31:0] word, input int clear_at);
        logic [15:0] c;
        logic [1:0]  e;
        c = crc_model(word);
        for (int k = 0; k < 60; k++) begin
            e = 2'b01;
            if (k == 1) e = 2'b00;
            else if (k >= 2 && k <= 33) e = {1'b0, word[33-k]};
            else if (k >= 34 && k <= 49) e = {1'b0, c[49-k]};
            else if (k == 51) e = 2'b11;
            if (clear_at >= 0 && k >= clear_at) e = 2'b01;
            tx_q.push_back(e);
        end
        data_in   = word;
        load_send = 1'b1;
        tick();
        for (int k = 0; k < 60; k++) begin
            e = tx_q.pop_front();
            check($sformatf("tx_cycle%0d", k), {62'd0, transmission_complete, dat_out}, {62'd0, e});
            if (k + 1 == clear_at) begin
                reset_wrapper = 1'b1;
                load_send     = 1'b0;
            end else begin
                reset_wrapper = 1'b0;
            end
            tick();
        end
        load_send     = 1'b0;
        reset_wrapper = 1'b0;
        tick();
    endtask

    // Drive the low `len` bits of frame (MSB first) onto dat_in.
    task automatic send_rx(input logic [49:0] frame, input int len, input logic [37:0] entry);
        waiting_response   = entry[37];
        enable_stp_wrapper = 1'b1;
        tick();
        exp_q.push_back(entry);
        exp_cyc_q.push_back(cyc + 1 + len);
        for (int i = len - 1; i >= 0; i--) begin
            dat_drv = frame[i];
            tick();
        end
        dat_drv = 1'b1;
        repeat (4) tick();
        enable_stp_wrapper = 1'b0;
        tick();
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic        mode;
        logic [31:0] word;
        logic [15:0] flip;
        logic        end_bit;
        logic [2:0]  tok;
        logic        exp_err;
        logic [2:0]  exp_status;
        logic        exp_ok;
    } rx_vec_t;

    rx_vec_t vecs[$];

    initial begin
        logic [49:0] frame;
        logic [37:0] entry;
        logic [31:0] w;
        rx_vec_t     v;

        vecs.push_back('{1'b0, 32'hA5C3_0F96, 16'h0000, 1'b1, 3'b000, 1'b0, 3'b000, 1'b0});
        vecs.push_back('{1'b0, 32'h0000_0000, 16'h0000, 1'b1, 3'b000, 1'b0, 3'b000, 1'b0});
        vecs.push_back('{1'b0, 32'hFFFF_FFFF, 16'h0000, 1'b1, 3'b000, 1'b0, 3'b000, 1'b0});
        vecs.push_back('{1'b0, 32'hA5C3_0F96, 16'h0020, 1'b1, 3'b000, 1'b1, 3'b000, 1'b0});
        vecs.push_back('{1'b0, 32'h1234_5678, 16'h0000, 1'b0, 3'b000, 1'b1, 3'b000, 1'b0});
        vecs.push_back('{1'b0, 32'hDEAD_BEEF, 16'h0000, 1'b1, 3'b000, 1'b0, 3'b000, 1'b0});
        vecs.push_back('{1'b1, 32'h0,         16'h0000, 1'b1, 3'b010, 1'b0, 3'b010, 1'b1});
        vecs.push_back('{1'b1, 32'h0,         16'h0000, 1'b1, 3'b101, 1'b0, 3'b101, 1'b0});
        vecs.push_back('{1'b1, 32'h0,         16'h0000, 1'b0, 3'b010, 1'b0, 3'b010, 1'b0});
        vecs.push_back('{1'b1, 32'h0,         16'h0000, 1'b1, 3'b111, 1'b0, 3'b111, 1'b0});
        for (int i = 0; i < 3; i++) begin
            w = $urandom_range(32'hFFFF_FFFF, 0);
            vecs.push_back('{1'b0, w, 16'h0000, 1'b1, 3'b000, 1'b0, 3'b000, 1'b0});
        end

        // Reset values
        repeat (3) tick();
        check("rst_dat_out", 64'(dat_out), 64'd1);
        check("rst_tx_done", 64'(transmission_complete), 64'd0);
        check("rst_rx_done", 64'(reception_complete), 64'd0);
        check("rst_dataRead", 64'(dataRead), 64'd0);
        check("rst_crc_status", 64'(crc_status), 64'd0);
        check("rst_status_ok", 64'(crc_status_ok), 64'd0);
        check("rst_crc_error", 64'(crc_error), 64'd0);
        reset = 1'b1;
        enable_pts_wrapper = 1'b1;
        tick();

        // TX zero word, load_send held across completion
        run_tx(32'h0000_0000, -1);

        // TX -> RX loopback: start bit sampled two edges after the load edge
        loop_en            = 1'b1;
        waiting_response   = 1'b0;
        enable_stp_wrapper = 1'b1;
        tick();
        exp_q.push_back({1'b0, 1'b0, 1'b0, 3'b000, 32'hA5C3_0F96});
        exp_cyc_q.push_back(cyc + 1 + 52);
        run_tx(32'hA5C3_0F96, -1);
        enable_stp_wrapper = 1'b0;
        loop_en            = 1'b0;
        tick();

        // Table-driven RX frames
        foreach (vecs[i]) begin
            v = vecs[i];
            if (v.mode) begin
                frame = {45'd0, 1'b0, v.tok, v.end_bit};
                entry = {1'b1, 1'b0, v.exp_ok, v.exp_status, 32'd0};
                send_rx(frame, 1 + TOKEN_W + 1, entry);
            end else begin
                frame = {1'b0, v.word, crc_model(v.word) ^ v.flip, v.end_bit};
                entry = {1'b0, v.exp_err, 1'b0, 3'b000, v.word};
                send_rx(frame, 1 + DATA_W + CRC_W + 1, entry);
            end
        end
        w = vecs[vecs.size()-1].word;

        // Abort mid data frame: no pulse, held results unchanged
        waiting_response   = 1'b0;
        enable_stp_wrapper = 1'b1;
        tick();
        dat_drv = 1'b0;
        tick();
        for (int i = 0; i < 12; i++) begin
            dat_drv = 1'($urandom_range(1, 0));
            tick();
        end
        enable_stp_wrapper = 1'b0;
        dat_drv            = 1'b1;
        repeat (60) tick();
        check("abort_dataRead", 64'(dataRead), 64'(w));
        check("abort_crc_status", 64'(crc_status), 64'd7);

        // dat_in low while RX disabled is ignored
        dat_drv = 1'b0;
        repeat (20) tick();
        dat_drv = 1'b1;
        tick();
        enable_stp_wrapper = 1'b1;
        repeat (60) tick();
        check("ignored_dataRead", 64'(dataRead), 64'(w));
        enable_stp_wrapper = 1'b0;
        tick();

        // Soft clear mid TX block, then in the completion cycle
        run_tx(32'h5A5A_F0F0, 20);
        check("clear_dataRead", 64'(dataRead), 64'd0);
        run_tx(32'h0123_4567, 51);

        // Leave held results non-zero, then hard reset
        send_rx({1'b0, 32'hCAFE_F00D, crc_model(32'hCAFE_F00D), 1'b0}, 50,
                {1'b0, 1'b1, 1'b0, 3'b000, 32'hCAFE_F00D});
        send_rx({45'd0, 1'b0, 3'b010, 1'b1}, 5, {1'b1, 1'b0, 1'b1, 3'b010, 32'd0});
        reset = 1'b0;
        tick();
        check("hrst_dat_out", 64'(dat_out), 64'd1);
        check("hrst_tx_done", 64'(transmission_complete), 64'd0);
        check("hrst_rx_done", 64'(reception_complete), 64'd0);
        check("hrst_dataRead", 64'(dataRead), 64'd0);
        check("hrst_crc_status", 64'(crc_status), 64'd0);
        check("hrst_status_ok", 64'(crc_status_ok), 64'd0);
        check("hrst_crc_error", 64'(crc_error), 64'd0);

        check("rx_pending", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
